retire_store_drain: RTL and testbench

- Consumer end of the retire interface's store path: accepts stores the ROB has committed, queues them in program order and drains them to the data memory write port over a valid/ready handshake.
- Sits between the retire stage and the data-memory/cache write port.
- Also reports whether a younger load overlaps a still-pending committed store, so the LSU can stall that load.
- Committed stores are architectural state; a pipeline flush never discards them.

---
 rtl/retire_store_drain.sv | 183 ++++++++++++++++++
 tb/tb_retire_store_drain.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_store_drain.sv
// retire_store_drain: in-order buffer of committed stores.
// Formats each store into a word-aligned write, queues it, and drains the
// queue to the data-memory write port. Also flags loads that overlap a
// pending (or same-cycle incoming) committed store.
//
// Handshake: mem_wr_valid is high whenever the buffer is non-empty; a
// transfer happens on a cycle where mem_wr_valid && mem_wr_ready. While
// valid is high and ready is low, addr/data/strb stay stable.
module retire_store_drain #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          retire_store_valid,
    input  logic [ADDR_WIDTH-1:0]         retire_store_addr,
    input  logic [DATA_WIDTH-1:0]         retire_store_data,
    input  logic [1:0]                    retire_store_size,
    output logic                          store_buf_full,
    output logic                          store_buf_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] store_buf_count,
    output logic                          store_err,
    output logic                          mem_wr_valid,
    input  logic                          mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    output logic [DATA_WIDTH/8-1:0]       mem_wr_strb,
    input  logic                          ld_query_valid,
    input  logic [ADDR_WIDTH-1:0]         ld_query_addr,
    output logic                          ld_conflict
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  err_q, err_d;
    logic [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic [ADDR_WIDTH-1:0] ent_addr_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] ent_addr_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ent_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ent_data_d [FIFO_DEPTH];
    logic [STRB_W-1:0]     ent_strb_q [FIFO_DEPTH];
    logic [STRB_W-1:0]     ent_strb_d [FIFO_DEPTH];

    logic [1:0]            off;
    logic                  fmt_legal;
    logic [STRB_W-1:0]     fmt_strb;
    logic [DATA_WIDTH-1:0] fmt_data;
    logic [ADDR_WIDTH-1:0] fmt_addr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [1:0]            unused_query_lsb;

    assign off              = retire_store_addr[1:0];
    assign unused_query_lsb = ld_query_addr[1:0];

    // Legality check and lane formatting of the incoming store.
    always_comb begin
        fmt_legal = 1'b0;
        fmt_strb  = '0;
        fmt_data  = retire_store_data << {off, 3'b000};
        fmt_addr  = {retire_store_addr[ADDR_WIDTH-1:2], 2'b00};
        case (retire_store_size)
            2'b00: begin
                fmt_legal = 1'b1;
                fmt_strb  = STRB_W'(4'b0001) << off;
            end
            2'b01: begin
                fmt_legal = !off[0];
                fmt_strb  = STRB_W'(4'b0011) << off;
            end
            2'b10: begin
                fmt_legal = (off == 2'b00);
                fmt_strb  = STRB_W'(4'b1111);
            end
            default: begin
                fmt_legal = 1'b0;
                fmt_strb  = '0;
            end
        endcase
    end

    // Full/empty come from the registered count, so a push is judged
    // against this cycle's occupancy even if a pop happens alongside it.
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = retire_store_valid && !full && fmt_legal;
    assign pop   = !empty && mem_wr_ready;

    // Next-state for pointers, count, sticky error and entry storage.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        err_d      = err_q;
        vld_d      = vld_q;
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_strb_d = ent_strb_q;

        if (retire_store_valid && (full || !fmt_legal)) begin
            err_d = 1'b1;
        end

        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end

        if (push) begin
            vld_d[tail_q]      = 1'b1;
            ent_addr_d[tail_q] = fmt_addr;
            ent_data_d[tail_q] = fmt_data;
            ent_strb_d[tail_q] = fmt_strb;
            tail_d             = tail_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            vld_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
                ent_strb_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
            ent_strb_q <= ent_strb_d;
        end
    end

    // Load overlap: any valid entry or a legal same-cycle push on the same
    // word. The head being popped this cycle still counts.
    always_comb begin
        ld_conflict = 1'b0;
        if (ld_query_valid) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (vld_q[i] &&
                    ent_addr_q[i][ADDR_WIDTH-1:2] == ld_query_addr[ADDR_WIDTH-1:2]) begin
                    ld_conflict = 1'b1;
                end
            end
            if (push && fmt_addr[ADDR_WIDTH-1:2] == ld_query_addr[ADDR_WIDTH-1:2]) begin
                ld_conflict = 1'b1;
            end
        end
    end

    assign store_buf_full  = full;
    assign store_buf_empty = empty;
    assign store_buf_count = count_q;
    assign store_err       = err_q;
    assign mem_wr_valid    = !empty;
    assign mem_wr_addr     = ent_addr_q[head_q];
    assign mem_wr_data     = ent_data_q[head_q];
    assign mem_wr_strb     = ent_strb_q[head_q];

endmodule

// File: tb/tb_retire_store_drain.sv
// Bench for retire_store_drain: directed scenarios plus a randomized run,
// all checked against a queue-based model of the committed-store buffer.
module tb_retire_store_drain;

    localparam int EW = 68; // {addr[31:0], data[31:0], strb[3:0]}

    logic        clk = 1'b0;
    logic        rst_n;
    logic        retire_store_valid;
    logic [31:0] retire_store_addr;
    logic [31:0] retire_store_data;
    logic [1:0]  retire_store_size;
    logic        store_buf_full;
    logic        store_buf_empty;
    logic [4:0]  store_buf_count;
    logic        store_err;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        ld_query_valid;
    logic [31:0] ld_query_addr;
    logic        ld_conflict;

    logic [EW-1:0] exp_q[$];
    bit            err_m;
    int            n_cmp  = 0;
    int            n_fail = 0;

    retire_store_drain #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .retire_store_valid (retire_store_valid),
        .retire_store_addr  (retire_store_addr),
        .retire_store_data  (retire_store_data),
        .retire_store_size  (retire_store_size),
        .store_buf_full     (store_buf_full),
        .store_buf_empty    (store_buf_empty),
        .store_buf_count    (store_buf_count),
        .store_err          (store_err),
        .mem_wr_valid       (mem_wr_valid),
        .mem_wr_ready       (mem_wr_ready),
        .mem_wr_addr        (mem_wr_addr),
        .mem_wr_data        (mem_wr_data),
        .mem_wr_strb        (mem_wr_strb),
        .ld_query_valid     (ld_query_valid),
        .ld_query_addr      (ld_query_addr),
        .ld_conflict        (ld_conflict)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    // A store of 2**size bytes at byte offset off covers bytes off..off+n-1
    // of the word; it is legal only when naturally aligned.
    function automatic void fmt_model(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] sz, output bit legal,
                                      output logic [EW-1:0] e);
        int          off;
        int          nb;
        logic [3:0]  s;
        logic [31:0] sd;
        off = int'(a[1:0]);
        nb  = 1 << sz;
        s   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) s[i] = 1'b1;
        end
        legal = (sz != 2'b11) && ((off % nb) == 0);
        sd    = d << (8 * off);
        e     = {a & 32'hFFFF_FFFC, sd, s};
    endfunction

    function automatic bit conflict_model();
        bit            legal;
        logic [EW-1:0] e;
        if (!ld_query_valid) return 1'b0;
        foreach (exp_q[i]) begin
            if (exp_q[i][67:38] == ld_query_addr[31:2]) return 1'b1;
        end
        fmt_model(retire_store_addr, retire_store_data, retire_store_size, legal, e);
        if (retire_store_valid && legal && exp_q.size() < 16 &&
            retire_store_addr[31:2] == ld_query_addr[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock (called at a negedge, returns at the next negedge),
    // updating the model from the inputs that were presented.
    task automatic tick();
        bit            legal;
        bit            do_push;
        bit            do_pop;
        logic [EW-1:0] e;
        fmt_model(retire_store_addr, retire_store_data, retire_store_size, legal, e);
        do_push = retire_store_valid && legal && exp_q.size() < 16;
        do_pop  = exp_q.size() > 0 && mem_wr_ready;
        if (retire_store_valid && (!legal || exp_q.size() >= 16)) err_m = 1'b1;
        @(posedge clk);
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_idle();
        retire_store_valid = 1'b0;
        retire_store_addr  = '0;
        retire_store_data  = '0;
        retire_store_size  = 2'b00;
        mem_wr_ready       = 1'b0;
        ld_query_valid     = 1'b0;
        ld_query_addr      = '0;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        retire_store_valid = 1'b1;
        retire_store_addr  = a;
        retire_store_data  = d;
        retire_store_size  = sz;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        exp_q.delete();
        err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        exp_q.delete();
        err_m = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (store_buf_empty !== 1'b1 || store_buf_full !== 1'b0 || store_buf_count !== 5'd0 ||
            store_err !== 1'b0 || mem_wr_valid !== 1'b0 || ld_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got empty=%b full=%b count=%0d err=%b valid=%b conf=%b, want 1 0 0 0 0 0",
                     store_buf_empty, store_buf_full, store_buf_count, store_err, mem_wr_valid, ld_conflict);
        end
        n_cmp++;
        if ({mem_wr_addr, mem_wr_data, mem_wr_strb} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_head: got %h %h %b, want zeros", mem_wr_addr, mem_wr_data, mem_wr_strb);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        mem_wr_ready = 1'b1;
        drive_store(32'h100, 32'hDEADBEEF, 2'b10);
        tick();
        retire_store_valid = 1'b0;
        n_cmp++;
        if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h100 || mem_wr_data !== 32'hDEADBEEF ||
            mem_wr_strb !== 4'b1111) begin
            n_fail++;
            $display("FAIL single_word: got v=%b %h %h %b, want 1 00000100 deadbeef 1111",
                     mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb);
        end
        tick();
        n_cmp++;
        if (store_buf_empty !== 1'b1 || store_buf_count !== 5'd0 || mem_wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drained: got empty=%b count=%0d valid=%b, want 1 0 0",
                     store_buf_empty, store_buf_count, mem_wr_valid);
        end
        set_idle();
    endtask

    task automatic test_lanes();
        mem_wr_ready = 1'b0;
        drive_store(32'h203, 32'h0000_00AB, 2'b00);
        tick();
        n_cmp++;
        if (mem_wr_addr !== 32'h200 || mem_wr_data !== 32'hAB00_0000 || mem_wr_strb !== 4'b1000) begin
            n_fail++;
            $display("FAIL byte_lane: got %h %h %b, want 00000200 ab000000 1000",
                     mem_wr_addr, mem_wr_data, mem_wr_strb);
        end
        mem_wr_ready = 1'b1;
        drive_store(32'h202, 32'h0000_1234, 2'b01);
        tick();
        retire_store_valid = 1'b0;
        n_cmp++;
        if (mem_wr_addr !== 32'h200 || mem_wr_data !== 32'h1234_0000 || mem_wr_strb !== 4'b1100 ||
            store_buf_count !== 5'd1) begin
            n_fail++;
            $display("FAIL half_lane: got %h %h %b cnt=%0d, want 00000200 12340000 1100 1",
                     mem_wr_addr, mem_wr_data, mem_wr_strb, store_buf_count);
        end
        tick();
        n_cmp++;
        if (store_buf_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL lanes_drained: got empty=%b, want 1", store_buf_empty);
        end
        set_idle();
    endtask

    task automatic test_full_backpressure();
        do_reset();
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_store(32'h1000 + 32'(i * 4), $urandom, 2'b10);
            tick();
            n_cmp++;
            if (mem_wr_valid !== 1'b1 || {mem_wr_addr, mem_wr_data, mem_wr_strb} !== exp_q[0] ||
                store_buf_count !== 5'(exp_q.size())) begin
                n_fail++;
                $display("FAIL fill_head[%0d]: got %h %h %b cnt=%0d, want %h cnt=%0d", i,
                         mem_wr_addr, mem_wr_data, mem_wr_strb, store_buf_count, exp_q[0], exp_q.size());
            end
        end
        n_cmp++;
        if (store_buf_full !== 1'b1 || store_buf_count !== 5'd16 || store_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flag: got full=%b count=%0d err=%b, want 1 16 0",
                     store_buf_full, store_buf_count, store_err);
        end
        drive_store(32'h2000, 32'h5555_AAAA, 2'b10);
        tick();
        retire_store_valid = 1'b0;
        n_cmp++;
        if (store_buf_count !== 5'd16 || store_err !== 1'b1) begin
            n_fail++;
            $display("FAIL push_when_full: got count=%0d err=%b, want 16 1", store_buf_count, store_err);
        end
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({mem_wr_addr, mem_wr_data, mem_wr_strb} !== exp_q[0] ||
                mem_wr_addr !== 32'h1000 + 32'(i * 4)) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: got %h %h %b, want %h", i,
                         mem_wr_addr, mem_wr_data, mem_wr_strb, exp_q[0]);
            end
            tick();
        end
        n_cmp++;
        if (store_buf_empty !== 1'b1 || mem_wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained: got empty=%b valid=%b, want 1 0", store_buf_empty, mem_wr_valid);
        end
        set_idle();
    endtask

    task automatic test_wrap();
        do_reset();
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h3000 + 32'(i * 4), $urandom, 2'b10);
            tick();
        end
        mem_wr_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_store(32'h3100 + 32'(i * 4), $urandom, 2'(i % 3));
            retire_store_addr = retire_store_addr + 32'((i % 3 == 0) ? (i % 4) : 0);
            tick();
            n_cmp++;
            if (store_buf_count !== 5'd3 || {mem_wr_addr, mem_wr_data, mem_wr_strb} !== exp_q[0]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got cnt=%0d head=%h %h %b, want cnt=3 head=%h", i,
                         store_buf_count, mem_wr_addr, mem_wr_data, mem_wr_strb, exp_q[0]);
            end
        end
        retire_store_valid = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (store_buf_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_drained: got empty=%b, want 1", store_buf_empty);
        end
        set_idle();
    endtask

    task automatic test_misalign();
        do_reset();
        drive_store(32'h102, 32'h1111_2222, 2'b10);
        tick();
        retire_store_valid = 1'b0;
        n_cmp++;
        if (store_buf_count !== 5'd0 || store_buf_empty !== 1'b1 || store_err !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_word: got count=%0d empty=%b err=%b, want 0 1 1",
                     store_buf_count, store_buf_empty, store_err);
        end
        do_reset();
        drive_store(32'h100, 32'h3333_4444, 2'b11);
        tick();
        retire_store_valid = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (store_buf_count !== 5'd0 || store_err !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_size_sticky: got count=%0d err=%b, want 0 1", store_buf_count, store_err);
        end
        do_reset();
        n_cmp++;
        if (store_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: got err=%b, want 0", store_err);
        end
        // Asynchronous reset with entries pending.
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h500 + 32'(i * 4), $urandom, 2'b10);
            tick();
        end
        retire_store_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (store_buf_count !== 5'd0 || store_buf_empty !== 1'b1 || mem_wr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got count=%0d empty=%b valid=%b, want 0 1 0",
                     store_buf_count, store_buf_empty, mem_wr_valid);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_ld_conflict();
        do_reset();
        mem_wr_ready = 1'b0;
        drive_store(32'h300, 32'hCAFE_F00D, 2'b10);
        tick();
        retire_store_valid = 1'b0;
        ld_query_valid = 1'b1;
        ld_query_addr  = 32'h302;
        #1;
        n_cmp++;
        if (ld_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_pending: got %b, want 1", ld_conflict);
        end
        ld_query_addr = 32'h304;
        #1;
        n_cmp++;
        if (ld_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_other_word: got %b, want 0", ld_conflict);
        end
        drive_store(32'h304, 32'h0000_0077, 2'b00);
        ld_query_addr = 32'h305;
        #1;
        n_cmp++;
        if (ld_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_incoming: got %b, want 1", ld_conflict);
        end
        tick();
        retire_store_valid = 1'b0;
        mem_wr_ready  = 1'b1;
        ld_query_addr = 32'h301;
        #1;
        n_cmp++;
        if (ld_conflict !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_popping_head: got %b, want 1", ld_conflict);
        end
        ld_query_valid = 1'b0;
        #1;
        n_cmp++;
        if (ld_conflict !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_no_query: got %b, want 0", ld_conflict);
        end
        repeat (2) tick();
        set_idle();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            retire_store_valid = ($urandom_range(0, 99) < 60);
            retire_store_addr  = 32'h400 + 32'($urandom_range(0, 31));
            retire_store_data  = $urandom;
            r = $urandom_range(0, 9);
            retire_store_size  = (r < 9) ? 2'(r % 3) : 2'b11;
            mem_wr_ready       = ($urandom_range(0, 99) < ((cyc < 200) ? 35 : 70));
            ld_query_valid     = ($urandom_range(0, 1) == 1);
            ld_query_addr      = 32'h400 + 32'($urandom_range(0, 39));
            #1;
            n_cmp++;
            if (ld_conflict !== conflict_model()) begin
                n_fail++;
                $display("FAIL rand_conflict[%0d]: got %b, want %b", cyc, ld_conflict, conflict_model());
            end
            tick();
            n_cmp++;
            if (store_buf_count !== 5'(exp_q.size()) || store_buf_full !== (exp_q.size() == 16) ||
                store_buf_empty !== (exp_q.size() == 0) || mem_wr_valid !== (exp_q.size() != 0) ||
                store_err !== err_m) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: got cnt=%0d full=%b empty=%b v=%b err=%b, want cnt=%0d err=%b",
                         cyc, store_buf_count, store_buf_full, store_buf_empty, mem_wr_valid,
                         store_err, exp_q.size(), err_m);
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                if ({mem_wr_addr, mem_wr_data, mem_wr_strb} !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got %h %h %b, want %h", cyc,
                             mem_wr_addr, mem_wr_data, mem_wr_strb, exp_q[0]);
                end
            end
        end
        set_idle();
        mem_wr_ready = 1'b1;
        repeat (17) tick();
        n_cmp++;
        if (store_buf_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_drained: got empty=%b, want 1", store_buf_empty);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_lanes();
        test_full_backpressure();
        test_wrap();
        test_misalign();
        test_ld_conflict();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
